// File: rtl/debug_uart_pkg.sv
// Shared types and helpers for the debug UART transmitter.
// DEBUG_UART_PARITY_EN adds the PARITY state (8E1 frames instead of 8N1).
package debug_uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

`ifdef DEBUG_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/debug_uart_fifo.sv
// Synchronous FIFO that buffers debug bytes ahead of the serializer.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module debug_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Debug byte stream transmitter: FIFO plus 8N1 serializer (8E1 when
// DEBUG_UART_PARITY_EN is defined). txd is registered and idles high.
module debug_uart_tx
    import debug_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    localparam int FIFO_AW     = $clog2(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         tx_Data,
    input  logic               tx_DataValid,
    input  logic               clear_overflow,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t      state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           bit_end;
`ifdef DEBUG_UART_PARITY_EN
    logic           parity_bit;
`endif

    debug_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_DataValid),
        .pop   (pop),
        .din   (tx_Data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (baud_cnt == BAUD_LAST);
    // Popping on the last STOP cycle lets the next start bit follow with no idle gap.
    assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy = (state != IDLE) || !fifo_empty;

    // A simultaneous drop beats a clear so no lost byte goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (tx_DataValid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    // txd reflects the state held during the previous cycle, one edge behind the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
`ifdef DEBUG_UART_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= fifo_dout;
`ifdef DEBUG_UART_PARITY_EN
                        parity_bit <= even_parity(fifo_dout);
`endif
                        state <= START;
                    end
                end
                START: begin
                    txd <= 1'b0;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    txd <= shift[0];
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == LAST_BIT) begin
`ifdef DEBUG_UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef DEBUG_UART_PARITY_EN
                PARITY: begin
                    txd <= parity_bit;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    txd <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_dout;
`ifdef DEBUG_UART_PARITY_EN
                            parity_bit <= even_parity(fifo_dout);
`endif
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
